// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU command sequencer and its combinational core.
package alu_seq_pkg;

  typedef enum logic [2:0] {
    ADD_RC   = 3'd0,
    ADD_OP   = 3'd1,
    LOGIC    = 3'd2,
    ANYONE   = 3'd3,
    POPMATCH = 3'd4,
    SWAPCMP  = 3'd5,
    HOLD     = 3'd6
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    EXEC  = 2'd2,
    DONE  = 2'd3
  } seq_state_t;

  localparam logic [7:0] ONES_LO = 8'h0F;
  localparam logic [7:0] ONES_HI = 8'hF0;

  function automatic logic [2:0] popcount4(input logic [3:0] v);
    popcount4 = 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
  endfunction

endpackage

// File: rtl/alu_op_sequencer_alu_core.sv
// Purely combinational 8-bit function ALU: (op, A, B) -> result.
module alu_core
  import alu_seq_pkg::*;
(
  input  logic [2:0] op_i,
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  output logic [7:0] result_o
);

  logic [3:0] rcSum;
  logic [4:0] carry;
  logic [4:0] opSum;

  // Explicit ripple-carry chain; carry[4] lands in result bit 4.
  always_comb begin
    carry[0] = 1'b0;
    rcSum    = '0;
    for (int i = 0; i < 4; i++) begin
      rcSum[i]     = a_i[i] ^ b_i[i] ^ carry[i];
      carry[i + 1] = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
    end
  end

  assign opSum = {1'b0, a_i} + {1'b0, b_i};

  // HOLD yields zero here; the sequencer simply skips the accumulator write.
  always_comb begin
    result_o = {3'b000, carry[4], rcSum};
    case (op_i)
      ADD_RC:   result_o = {3'b000, carry[4], rcSum};
      ADD_OP:   result_o = {3'b000, opSum};
      LOGIC:    result_o = {~(a_i & b_i), ~(a_i ^ b_i)};
      ANYONE:   result_o = (|{a_i, b_i}) ? ONES_LO : 8'h00;
      POPMATCH: result_o = ((popcount4(a_i) == 3'd1) && (popcount4(b_i) == 3'd2)) ? ONES_HI : 8'h00;
      SWAPCMP:  result_o = {a_i, ~b_i};
      HOLD:     result_o = 8'h00;
      default:  result_o = {3'b000, carry[4], rcSum};
    endcase
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Command FIFO plus issue FSM driving the ALU core; results accumulate in acc,
// whose low nibble feeds back as the B operand of the next command.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [2:0]    cmd_op,
  input  logic [3:0]    cmd_a,
  input  logic          cmd_last,
  output logic [7:0]    acc,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] fifo_count
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] count_q;
  seq_state_t    state_q, state_d;
  logic [2:0]    op_q;
  logic [3:0]    a_q;
  logic          last_q;
  logic [7:0]    acc_q;
  logic          busy_q, done_q;
  logic          push, pop, notEmpty;
  logic [7:0]    aluResult;

  alu_core u_core (
    .op_i     (op_q),
    .a_i      (a_q),
    .b_i      (acc_q[3:0]),
    .result_o (aluResult)
  );

  assign cmd_ready  = (count_q != CW'(DEPTH)) & ~reset;
  assign push       = cmd_valid & cmd_ready;
  assign notEmpty   = (count_q != '0);
  assign acc        = acc_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign fifo_count = count_q;

  // Only ISSUE pops, and ISSUE is reached only with a non-empty FIFO.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      IDLE:    if (notEmpty) state_d = ISSUE;
      ISSUE: begin
        pop     = 1'b1;
        state_d = EXEC;
      end
      EXEC: begin
        if (last_q)        state_d = DONE;
        else if (notEmpty) state_d = ISSUE;
        else               state_d = IDLE;
      end
      DONE:    state_d = notEmpty ? ISSUE : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (push) mem_q[wr_q] <= {cmd_op, cmd_a, cmd_last};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      op_q    <= '0;
      a_q     <= '0;
      last_q  <= 1'b0;
      acc_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (push) wr_q <= wr_q + AW'(1);
      if (pop) begin
        rd_q                  <= rd_q + AW'(1);
        {op_q, a_q, last_q}   <= mem_q[rd_q];
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      if ((state_q == EXEC) && (op_q != 3'(HOLD))) acc_q <= aluResult;
      busy_q <= (state_d != IDLE);
      done_q <= (state_d == DONE);
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed and random stimulus for alu_op_sequencer; expected accumulator values
// are queued at command acceptance and checked after every EXEC.
module tb_alu_op_sequencer;
  import alu_seq_pkg::*;

  logic       clock;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [3:0] cmd_a;
  logic       cmd_last;
  logic [7:0] acc;
  logic       busy;
  logic       done;
  logic [2:0] fifo_count;

  int         testCount = 0;
  int         failCount = 0;
  int         execCnt   = 0;
  int         doneCount = 0;
  logic       pendingExec = 1'b0;
  logic       sawFull = 1'b0;
  logic [7:0] mdlAcc = 8'h00;
  logic [7:0] expAcc;
  logic [7:0] sbQ[$];

  alu_op_sequencer #(.DEPTH(4), .CW(3)) dut (
    .clock      (clock),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_a      (cmd_a),
    .cmd_last   (cmd_last),
    .acc        (acc),
    .busy       (busy),
    .done       (done),
    .fifo_count (fifo_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [7:0] aluRef(input logic [2:0] op, input logic [3:0] a, input logic [7:0] cur);
    logic [3:0] b;
    b = cur[3:0];
    case (op)
      3'd2:    aluRef = {~(a & b), ~(a ^ b)};
      3'd3:    aluRef = ({a, b} != 8'h00) ? 8'h0F : 8'h00;
      3'd4:    aluRef = (($countones(a) == 1) && ($countones(b) == 2)) ? 8'hF0 : 8'h00;
      3'd5:    aluRef = {a, ~b};
      3'd6:    aluRef = cur;
      default: aluRef = {3'b000, {1'b0, a} + {1'b0, b}};
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    testCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Holds the command until accepted; the expected result is queued at acceptance.
  task automatic applyStimulus(input logic [2:0] op, input logic [3:0] a, input logic last);
    int guard;
    guard     = 0;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_a     = a;
    cmd_last  = last;
    forever begin
      @(negedge clock);
      if (cmd_ready === 1'b1) begin
        mdlAcc = aluRef(op, a, mdlAcc);
        sbQ.push_back(mdlAcc);
        break;
      end
      guard++;
      if (guard > 500) begin
        testCount++;
        failCount++;
        $error("[TB] FAIL pushTimeout: cmd_ready observed %b expected 1", cmd_ready);
        break;
      end
    end
    @(posedge clock);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic waitDrain();
    int guard;
    guard = 0;
    while ((sbQ.size() != 0 || busy !== 1'b0 || fifo_count !== 3'd0) && guard < 4000) begin
      @(negedge clock);
      #1 guard++;
    end
    if (guard >= 4000) begin
      testCount++;
      failCount++;
      $error("[TB] FAIL drainTimeout: pending %0d busy %b count %0d expected 0 0 0", sbQ.size(), busy, fifo_count);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic doReset();
    @(negedge clock);
    #1 reset = 1'b1;
    cmd_valid = 1'b0;
    @(negedge clock);
    @(negedge clock);
    #1 sbQ.delete();
    mdlAcc = 8'h00;
    @(posedge clock);
    #1 reset = 1'b0;
  endtask

  // Result of an EXEC cycle is visible one edge later unless reset intervened.
  always @(negedge clock) begin
    if (pendingExec && !reset) begin
      if (sbQ.size() == 0) begin
        testCount++;
        failCount++;
        $error("[TB] FAIL sbEmpty: observed acc %h with no expected entry", acc);
      end else begin
        expAcc = sbQ.pop_front();
        checkOutput("accAfterExec", acc, expAcc);
      end
    end
    pendingExec = !reset && (dut.state_q == EXEC);
    if (pendingExec) execCnt++;
    if (done === 1'b1) doneCount++;
    if (!reset && fifo_count === 3'd4) begin
      sawFull = 1'b1;
      checkOutput("readyFull", {7'd0, cmd_ready}, 8'd0);
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int base;
    int doneBase;
    int guard;
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 3'd0;
    cmd_a     = 4'd0;
    cmd_last  = 1'b0;

    repeat (2) @(negedge clock);
    checkOutput("rstAcc", acc, 8'h00);
    checkOutput("rstCount", {5'd0, fifo_count}, 8'd0);
    checkOutput("rstBusy", {7'd0, busy}, 8'd0);
    checkOutput("rstDone", {7'd0, done}, 8'd0);
    checkOutput("rstReady", {7'd0, cmd_ready}, 8'd0);
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    checkOutput("readyAfterRst", {7'd0, cmd_ready}, 8'd1);
    @(posedge clock);
    #1;

    // Latency: done and the new acc appear in the 3rd cycle after the push edge.
    applyStimulus(3'd0, 4'd5, 1'b1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      if (k == 0) checkOutput("latCount", {5'd0, fifo_count}, 8'd1);
      checkOutput("latNoDone", {7'd0, done}, 8'd0);
    end
    @(negedge clock);
    checkOutput("latDone", {7'd0, done}, 8'd1);
    checkOutput("latAcc", acc, 8'h05);
    @(negedge clock);
    checkOutput("donePulse", {7'd0, done}, 8'd0);
    @(posedge clock);
    #1;

    applyStimulus(3'd1, 4'd9, 1'b1);
    waitDrain();
    checkOutput("addOpAcc", acc, 8'h0E);

    applyStimulus(3'd2, 4'b1010, 1'b1);
    waitDrain();
    checkOutput("logicAcc", acc, 8'h5B);

    doReset();
    doneBase = doneCount;
    applyStimulus(3'd5, 4'd3, 1'b0);
    applyStimulus(3'd6, 4'hF, 1'b0);
    applyStimulus(3'd4, 4'd1, 1'b1);
    waitDrain();
    checkOutput("popmatchAcc", acc, 8'h00);
    checkOutput("oneDone", 8'(doneCount - doneBase), 8'd1);

    // Back-to-back pushes outpace the 2-cycle issue rate and fill the FIFO.
    sawFull = 1'b0;
    for (int i = 0; i < 10; i++)
      applyStimulus((i % 3 == 0) ? 3'd5 : 3'd0, 4'(i + 1), (i == 9));
    waitDrain();
    checkOutput("sawFull", {7'd0, sawFull}, 8'd1);

    // Reset during EXEC of the 2nd of 3 commands.
    base     = execCnt;
    doneBase = doneCount;
    applyStimulus(3'd0, 4'd1, 1'b0);
    applyStimulus(3'd0, 4'd2, 1'b0);
    applyStimulus(3'd0, 4'd3, 1'b1);
    guard = 0;
    while (execCnt < base + 2 && guard < 100) begin
      @(negedge clock);
      #1 guard++;
    end
    checkOutput("reachedExec2", 8'(execCnt - base), 8'd2);
    reset = 1'b1;
    @(negedge clock);
    checkOutput("midRstAcc", acc, 8'h00);
    checkOutput("midRstCount", {5'd0, fifo_count}, 8'd0);
    checkOutput("midRstBusy", {7'd0, busy}, 8'd0);
    checkOutput("midRstDone", {7'd0, done}, 8'd0);
    checkOutput("midRstReady", {7'd0, cmd_ready}, 8'd0);
    #1 sbQ.delete();
    mdlAcc = 8'h00;
    @(posedge clock);
    #1 reset = 1'b0;
    repeat (3) @(negedge clock);
    checkOutput("midRstNoDone", 8'(doneCount - doneBase), 8'd0);
    @(posedge clock);
    #1;

    doneBase = doneCount;
    for (int i = 0; i < 40; i++)
      applyStimulus(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), (i % 8 == 7));
    waitDrain();
    checkOutput("randDones", 8'(doneCount - doneBase), 8'd5);

    // Every {A,B} pair through op0 and op1, each preceded by forcing acc to B.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        applyStimulus(3'd4, 4'd0, 1'b0);
        applyStimulus(3'd0, 4'(b), 1'b0);
        applyStimulus(3'd0, 4'(a), 1'b0);
        applyStimulus(3'd4, 4'd0, 1'b0);
        applyStimulus(3'd1, 4'(b), 1'b0);
        applyStimulus(3'd1, 4'(a), (b == 15));
      end
    end
    waitDrain();
    checkOutput("finalAcc", acc, 8'(8'd15 + 8'd15));

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
